// File: rtl/line_seq_pkg.sv
// Shared helpers and types for the line window sequencer.
// Optional border replication is selected with LINE_SEQ_BORDER_REPLICATE_EN.
package line_seq_pkg;

  localparam int PIX_W_DEF = 8;

  // Ring-buffer address width: two lines of storage.
  function automatic int addr_w(input int line_w);
    return (2 * line_w > 1) ? $clog2(2 * line_w) : 1;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

  // One vertical column, oldest row in the MSBs.
  typedef struct packed {
    logic [PIX_W_DEF-1:0] row_m2;
    logic [PIX_W_DEF-1:0] row_m1;
    logic [PIX_W_DEF-1:0] row_0;
  } col_t;

endpackage

// File: rtl/line_window_sequencer_wrap_counter.sv
// Modulo-(MAX+1) counter; clr_i zeroes the value seen this cycle so a
// restart and a count can happen together.
module wrap_counter
  import line_seq_pkg::*;
#(
  parameter int MAX   = 3,
  parameter int WIDTH = cnt_w(MAX)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;

  assign cnt_o  = clr_i ? '0 : cnt_reg;
  assign wrap_o = en_i && (cnt_o == MAX_V);

  always_comb begin
    cnt_next = cnt_reg;
    if (en_i) begin
      cnt_next = wrap_o ? '0 : cnt_o + WIDTH'(1);
    end else if (clr_i) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/line_window_sequencer.sv
// Two-line ring buffer sequencer producing 3-pixel vertical columns.
// Define LINE_SEQ_BORDER_REPLICATE_EN to replicate pixels on rows 0 and 1.
module line_window_sequencer
  import line_seq_pkg::*;
#(
  parameter int PIX_W_P   = 8,
  parameter int LINE_W_P  = 640,
  parameter int FRAME_H_P = 480
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [PIX_W_P-1:0]            pix_i,
  input  logic                          sof_i,
  input  logic                          pix_valid_i,
  output logic                          pix_ready_o,
  output logic [PIX_W_P-1:0]            ram_data_o,
  output logic [$clog2(2*LINE_W_P)-1:0] ram_wr_addr_o,
  output logic                          ram_wr_en_o,
  output logic [$clog2(2*LINE_W_P)-1:0] ram_rd_addr_a_o,
  output logic [$clog2(2*LINE_W_P)-1:0] ram_rd_addr_b_o,
  output logic                          ram_rd_en_a_o,
  output logic                          ram_rd_en_b_o,
  input  logic [PIX_W_P-1:0]            ram_data_a_i,
  input  logic [PIX_W_P-1:0]            ram_data_b_i,
  output logic [3*PIX_W_P-1:0]          col_o,
  output logic                          col_valid_o,
  input  logic                          col_ready_i,
  output logic                          rows_ok_o,
  output logic                          col_eol_o,
  output logic                          col_eof_o
);

  localparam int ADDR_W = addr_w(LINE_W_P);
  localparam int XW     = cnt_w(LINE_W_P - 1);
  localparam int YW     = cnt_w(FRAME_H_P - 1);

  logic              accept;
  logic              sof_acc;
  logic [XW-1:0]     x_eff;
  logic [YW-1:0]     y_eff;
  logic              x_wrap;
  logic              y_wrap;
  logic              slot_reg;
  logic              slot_next;
  logic              slot_eff;
  logic [ADDR_W-1:0] x_addr;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;

  logic               col_valid_reg;
  logic [PIX_W_P-1:0] pix_q_reg;
  logic               rows_ok_reg;
  logic               eol_reg;
  logic               eof_reg;

  assign pix_ready_o = !col_valid_reg || col_ready_i;
  assign accept      = pix_valid_i && pix_ready_o;
  assign sof_acc     = accept && sof_i;

  wrap_counter #(.MAX(LINE_W_P - 1), .WIDTH(XW)) u_x_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (accept),
    .clr_i  (sof_acc),
    .cnt_o  (x_eff),
    .wrap_o (x_wrap)
  );

  wrap_counter #(.MAX(FRAME_H_P - 1), .WIDTH(YW)) u_y_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (x_wrap),
    .clr_i  (sof_acc),
    .cnt_o  (y_eff),
    .wrap_o (y_wrap)
  );

  // The slot names the half holding row y-2, which row y overwrites.
  assign slot_eff = sof_acc ? 1'b0 : slot_reg;

  always_comb begin
    slot_next = slot_reg;
    if (accept) begin
      if (x_wrap) begin
        slot_next = y_wrap ? 1'b0 : !slot_eff;
      end else begin
        slot_next = slot_eff;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_reg <= 1'b0;
    end else begin
      slot_reg <= slot_next;
    end
  end

  assign x_addr    = ADDR_W'(x_eff);
  assign line_base = ADDR_W'(LINE_W_P);
  assign rd_addr_b = slot_eff ? line_base + x_addr : x_addr;
  assign rd_addr_a = slot_eff ? x_addr : line_base + x_addr;

  // Read-before-write on the same address keeps row y-2 visible this cycle.
  assign ram_rd_addr_a_o = rd_addr_a;
  assign ram_rd_addr_b_o = rd_addr_b;
  assign ram_wr_addr_o   = rd_addr_b;
  assign ram_data_o      = pix_i;
  assign ram_wr_en_o     = accept;
  assign ram_rd_en_a_o   = accept;
  assign ram_rd_en_b_o   = accept;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_valid_reg <= 1'b0;
      pix_q_reg     <= '0;
      rows_ok_reg   <= 1'b0;
      eol_reg       <= 1'b0;
      eof_reg       <= 1'b0;
    end else if (accept) begin
      col_valid_reg <= 1'b1;
      pix_q_reg     <= pix_i;
      rows_ok_reg   <= (32'(y_eff) >= 32'd2);
      eol_reg       <= x_wrap;
      eof_reg       <= x_wrap && y_wrap;
    end else if (col_ready_i) begin
      col_valid_reg <= 1'b0;
    end
  end

`ifdef LINE_SEQ_BORDER_REPLICATE_EN
  logic y_zero_reg;
  logic y_one_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      y_zero_reg <= 1'b0;
      y_one_reg  <= 1'b0;
    end else if (accept) begin
      y_zero_reg <= (32'(y_eff) == 32'd0);
      y_one_reg  <= (32'(y_eff) == 32'd1);
    end
  end

  always_comb begin
    col_o = {ram_data_b_i, ram_data_a_i, pix_q_reg};
    if (y_zero_reg) begin
      col_o = {pix_q_reg, pix_q_reg, pix_q_reg};
    end else if (y_one_reg) begin
      col_o = {ram_data_a_i, ram_data_a_i, pix_q_reg};
    end
  end
`else
  // RAM outputs hold while stalled, so the column needs no skid storage.
  assign col_o = {ram_data_b_i, ram_data_a_i, pix_q_reg};
`endif

  assign col_valid_o = col_valid_reg;
  assign rows_ok_o   = rows_ok_reg;
  assign col_eol_o   = eol_reg;
  assign col_eof_o   = eof_reg;

endmodule

// File: tb/tb_line_window_sequencer.sv
// Directed bench for line_window_sequencer with a two-port RAM stand-in and a
// frame-image reference model.
`define CHK(nm, a, e) chk(nm, 32'(a), 32'(e))

module tb_line_window_sequencer;
  import line_seq_pkg::*;

  localparam int P  = 8;
  localparam int LW = 4;
  localparam int FH = 4;
  localparam int AW = $clog2(2 * LW);

  logic          clk_i;
  logic          rst_i;
  logic [P-1:0]  pix_i;
  logic          sof_i;
  logic          pix_valid_i;
  logic          pix_ready_o;
  logic [P-1:0]  ram_data_o;
  logic [AW-1:0] ram_wr_addr_o;
  logic          ram_wr_en_o;
  logic [AW-1:0] ram_rd_addr_a_o;
  logic [AW-1:0] ram_rd_addr_b_o;
  logic          ram_rd_en_a_o;
  logic          ram_rd_en_b_o;
  logic [P-1:0]  ram_data_a_i;
  logic [P-1:0]  ram_data_b_i;
  logic [3*P-1:0] col_o;
  logic          col_valid_o;
  logic          col_ready_i;
  logic          rows_ok_o;
  logic          col_eol_o;
  logic          col_eof_o;

  int n_cmp = 0;
  int n_bad = 0;

  line_window_sequencer #(.PIX_W_P(P), .LINE_W_P(LW), .FRAME_H_P(FH)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pix_i           (pix_i),
    .sof_i           (sof_i),
    .pix_valid_i     (pix_valid_i),
    .pix_ready_o     (pix_ready_o),
    .ram_data_o      (ram_data_o),
    .ram_wr_addr_o   (ram_wr_addr_o),
    .ram_wr_en_o     (ram_wr_en_o),
    .ram_rd_addr_a_o (ram_rd_addr_a_o),
    .ram_rd_addr_b_o (ram_rd_addr_b_o),
    .ram_rd_en_a_o   (ram_rd_en_a_o),
    .ram_rd_en_b_o   (ram_rd_en_b_o),
    .ram_data_a_i    (ram_data_a_i),
    .ram_data_b_i    (ram_data_b_i),
    .col_o           (col_o),
    .col_valid_o     (col_valid_o),
    .col_ready_i     (col_ready_i),
    .rows_ok_o       (rows_ok_o),
    .col_eol_o       (col_eol_o),
    .col_eof_o       (col_eof_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [P-1:0] pv(input int f, input int x, input int y);
    return P'(100 * (f % 2) + 10 * y + x);
  endfunction

  // Two-port RAM stand-in: registered reads return pre-write data, stale fill.
  logic [P-1:0] mem [2*LW];
  initial begin
    for (int i = 0; i < 2 * LW; i++) mem[i] = 8'hEE;
    ram_data_a_i = '0;
    ram_data_b_i = '0;
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i) begin
        ram_data_a_i = '0;
        ram_data_b_i = '0;
      end else begin
        if (ram_rd_en_a_o) ram_data_a_i = mem[ram_rd_addr_a_o];
        if (ram_rd_en_b_o) ram_data_b_i = mem[ram_rd_addr_b_o];
        if (ram_wr_en_o) mem[ram_wr_addr_o] = ram_data_o;
      end
    end
  end

  // Reference model: raster position plus an image of the current frame.
  int           m_n = 0;
  bit           m_valid = 0;
  logic [P-1:0] m_pix = '0;
  logic [P-1:0] m_top = '0;
  logic [P-1:0] m_mid = '0;
  bit           m_rows_ok = 0;
  bit           m_eol = 0;
  bit           m_eof = 0;
  int           m_ycol = 0;
  logic [P-1:0] img [FH][LW];

  initial begin
    forever begin : mdl
      int xe;
      int ye;
      bit rdy;
      @(posedge clk_i or posedge rst_i);
      if (rst_i) begin
        m_n = 0; m_valid = 0; m_pix = '0;
        m_rows_ok = 0; m_eol = 0; m_eof = 0;
      end else begin
        rdy = !m_valid || col_ready_i;
        if (pix_valid_i && rdy) begin
          xe = sof_i ? 0 : m_n % LW;
          ye = sof_i ? 0 : m_n / LW;
          m_top = (ye >= 2) ? img[ye-2][xe] : '0;
          m_mid = (ye >= 1) ? img[ye-1][xe] : '0;
          img[ye][xe] = pix_i;
          m_pix = pix_i;
          m_ycol = ye;
          m_rows_ok = (ye >= 2);
          m_eol = (xe == LW - 1);
          m_eof = m_eol && (ye == FH - 1);
          m_valid = 1;
          m_n = (ye * LW + xe + 1) % (LW * FH);
        end else if (col_ready_i) begin
          m_valid = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin : cmp
      bit rdy;
      bit acc;
      int xe;
      int ye;
      col_t c;
      @(negedge clk_i);
      if (!rst_i) begin
        rdy = !m_valid || col_ready_i;
        acc = pix_valid_i && rdy;
        `CHK("pix_ready", pix_ready_o, rdy);
        `CHK("wr_en", ram_wr_en_o, acc);
        `CHK("rd_en_a", ram_rd_en_a_o, acc);
        `CHK("rd_en_b", ram_rd_en_b_o, acc);
        if (acc) begin
          xe = sof_i ? 0 : m_n % LW;
          ye = sof_i ? 0 : m_n / LW;
          `CHK("wr_addr", ram_wr_addr_o, (ye % 2) * LW + xe);
          `CHK("rd_addr_b", ram_rd_addr_b_o, (ye % 2) * LW + xe);
          `CHK("rd_addr_a", ram_rd_addr_a_o, ((ye + 1) % 2) * LW + xe);
          `CHK("wr_data", ram_data_o, pix_i);
        end
        `CHK("col_valid", col_valid_o, m_valid);
        if (m_valid) begin
          c = col_o;
          `CHK("col_row0", c.row_0, m_pix);
          `CHK("rows_ok", rows_ok_o, m_rows_ok);
          `CHK("eol", col_eol_o, m_eol);
          `CHK("eof", col_eof_o, m_eof);
`ifdef LINE_SEQ_BORDER_REPLICATE_EN
          if (m_ycol == 0) begin
            `CHK("col_m1_rep0", c.row_m1, m_pix);
            `CHK("col_m2_rep0", c.row_m2, m_pix);
          end else if (m_ycol == 1) begin
            `CHK("col_m1_rep1", c.row_m1, m_mid);
            `CHK("col_m2_rep1", c.row_m2, m_mid);
          end else begin
            `CHK("col_m1", c.row_m1, m_mid);
            `CHK("col_m2", c.row_m2, m_top);
          end
`else
          if (m_rows_ok) begin
            `CHK("col_m1", c.row_m1, m_mid);
            `CHK("col_m2", c.row_m2, m_top);
          end
`endif
        end
      end
    end
  end

  task automatic send(input logic [P-1:0] p, input bit s);
    int guard;
    guard = 0;
    pix_i = p; sof_i = s; pix_valid_i = 1'b1;
    @(negedge clk_i);
    while (!pix_ready_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    n_cmp++;
    if (!pix_ready_o) begin
      n_bad++;
      $display("FAIL send_timeout: pix_ready stayed 0, expected 1 within 50 cycles");
    end
    @(posedge clk_i);
    #2;
    pix_valid_i = 1'b0; sof_i = 1'b0;
  endtask

  task automatic peek(input logic [P-1:0] p, input bit s, input int wa, input int ra, input int rb);
    pix_i = p; sof_i = s; pix_valid_i = 1'b1;
    #1;
    `CHK("peek_wr_addr", ram_wr_addr_o, wa);
    `CHK("peek_rd_addr_a", ram_rd_addr_a_o, ra);
    `CHK("peek_rd_addr_b", ram_rd_addr_b_o, rb);
  endtask

  initial begin
    rst_i = 1'b1; pix_valid_i = 1'b0; sof_i = 1'b0; pix_i = '0; col_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #2;
    `CHK("rst_col_valid", col_valid_o, 0);
    `CHK("rst_col", col_o, 0);
    `CHK("rst_rows_ok", rows_ok_o, 0);
    `CHK("rst_eol", col_eol_o, 0);
    `CHK("rst_eof", col_eof_o, 0);
    `CHK("rst_pix_ready", pix_ready_o, 1);
    rst_i = 1'b0;

    // Frame 0, continuous stream.
    for (int y = 0; y < FH; y++) begin
      for (int x = 0; x < LW; x++) begin
        send(pv(0, x, y), (x == 0 && y == 0));
        if (x == 1 && y == 0) begin
          `CHK("lit_rows_ok_10", rows_ok_o, 0);
`ifdef LINE_SEQ_BORDER_REPLICATE_EN
          `CHK("lit_rep_10", col_o, 24'h010101);
`endif
        end
        if (x == 1 && y == 1) begin
          `CHK("lit_rows_ok_11", rows_ok_o, 0);
`ifdef LINE_SEQ_BORDER_REPLICATE_EN
          `CHK("lit_rep_11", col_o, 24'h01010B);
`endif
        end
        if (x == 2 && y == 2) begin
          `CHK("lit_valid_22", col_valid_o, 1);
          `CHK("lit_col_22", col_o, 24'h020C16);
          `CHK("lit_rows_ok_22", rows_ok_o, 1);
        end
        if (x == 3 && y == 3) begin
          `CHK("lit_eol_33", col_eol_o, 1);
          `CHK("lit_eof_33", col_eof_o, 1);
        end
      end
    end

    // Frame 1 without sof: wrap must land on slot 0, x 0.
    peek(pv(1, 0, 0), 1'b0, 0, 4, 0);
    for (int i = 0; i < 9; i++) send(pv(1, i % LW, i / LW), 1'b0);

    // Downstream stall with a pixel pending.
    col_ready_i = 1'b0;
    pix_i = pv(1, 1, 2); sof_i = 1'b0; pix_valid_i = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      `CHK("stall_pix_ready", pix_ready_o, 0);
      `CHK("stall_wr_en", ram_wr_en_o, 0);
      `CHK("stall_col", col_o, 24'h646E78);
    end
    @(posedge clk_i);
    #2;
    col_ready_i = 1'b1;
    send(pv(1, 1, 2), 1'b0);
    `CHK("release_col", col_o, 24'h656F79);
    for (int i = 10; i < LW * FH; i++) send(pv(1, i % LW, i / LW), 1'b0);

    // Frame 2 up to (1,1), then sof where (2,1) would be.
    for (int i = 0; i < 6; i++) send(pv(2, i % LW, i / LW), (i == 0));
    peek(pv(3, 0, 0), 1'b1, 0, 4, 0);
    send(pv(3, 0, 0), 1'b1);
    for (int i = 1; i < 12; i++) send(pv(3, i % LW, i / LW), 1'b0);

    // Reset mid-line while a column is valid.
    #1;
    rst_i = 1'b1;
    #1;
    `CHK("midrst_col_valid", col_valid_o, 0);
    `CHK("midrst_rows_ok", rows_ok_o, 0);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    peek(pv(0, 0, 0), 1'b0, 0, 4, 0);
    for (int i = 0; i < LW * FH; i++) send(pv(0, i % LW, i / LW), 1'b0);

    repeat (3) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/line_window_sequencer.md
Name: line_window_sequencer

Overview:
- Drives the write port and both read ports of a sync_ram_block instance with DEPTH_P = 2*LINE_W_P, WIDTH_P = PIX_W_P.
- Accepts a raster pixel stream and uses the RAM as a two-line ring buffer.
- Emits one vertical 3-pixel column per accepted pixel (rows y-2, y-1, y) to the Sobel window stage.

Parameters:
- PIX_W_P, 8, pixel width in bits.
- LINE_W_P, 640, pixels per line.
- FRAME_H_P, 480, lines per frame.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous reset, active-high.
- pix_i  in  PIX_W_P  input pixel.
- sof_i  in  1  start of frame; qualified by pix_valid_i.
- pix_valid_i  in  1  input valid.
- pix_ready_o  out  1  input ready.
- ram_data_o  out  PIX_W_P  RAM write data.
- ram_wr_addr_o  out  $clog2(2*LINE_W_P)  RAM write address.
- ram_wr_en_o  out  1  RAM write enable.
- ram_rd_addr_a_o  out  $clog2(2*LINE_W_P)  RAM read address, port A (row y-1).
- ram_rd_addr_b_o  out  $clog2(2*LINE_W_P)  RAM read address, port B (row y-2).
- ram_rd_en_a_o  out  1  RAM read enable, port A.
- ram_rd_en_b_o  out  1  RAM read enable, port B.
- ram_data_a_i  in  PIX_W_P  RAM read data, port A; 1-cycle latency.
- ram_data_b_i  in  PIX_W_P  RAM read data, port B; 1-cycle latency.
- col_o  out  3*PIX_W_P  column: [3P-1:2P] = row y-2, [2P-1:P] = row y-1, [P-1:0] = row y.
- col_valid_o  out  1  column valid.
- col_ready_i  in  1  downstream ready.
- rows_ok_o  out  1  column row y >= 2, so both buffered rows are real.
- col_eol_o  out  1  column is at x = LINE_W_P-1.
- col_eof_o  out  1  column is the last pixel of the frame.

Behaviour:
- Reset (async, rst_i=1):
  - x_cnt = 0, y_cnt = 0, slot = 0.
  - col_valid_o = 0; col_o, rows_ok_o, col_eol_o, col_eof_o = 0.
  - Requires the RAM rstn_i tied to ~rst_i.
- Handshake:
  - pix_ready_o = !col_valid_o || col_ready_i (combinational).
  - accept = pix_valid_i && pix_ready_o.
- On accept, same cycle:
  - ram_rd_en_a_o = ram_rd_en_b_o = ram_wr_en_o = 1.
  - rd_addr_a = (~slot)*LINE_W_P + x_eff.
  - rd_addr_b = slot*LINE_W_P + x_eff.
  - wr_addr = rd_addr_b, wr data = pix_i. The RAM returns pre-write data, so row y-2 is read before it is overwritten.
  - x_eff = 0 if sof_i, else x_cnt.
- No accept: all RAM enables are 0. RAM outputs hold, so a stalled column is preserved without a skid buffer.
- Output registers, updated on accept:
  - col_valid_o <= 1; pix_q <= pix_i.
  - rows_ok, eol and eof flags are registered from y_eff/x_eff.
  - col_o is composed combinationally: {ram_data_b_i, ram_data_a_i, pix_q}.
  - Latency: 1 cycle from accept to col_valid_o.
- No accept and col_ready_i=1: col_valid_o <= 0.
- Counters:
  - x wraps at LINE_W_P-1 to 0.
  - On x wrap: y increments and slot toggles.
  - y wraps at FRAME_H_P-1 to 0; slot resets to 0.
- sof_i with accept mid-frame: x, y and slot are forced to 0 before addressing; the pixel is treated as (0,0).
- rows_ok_o = (y_eff >= 2).
- Address arithmetic is unsigned at $clog2(2*LINE_W_P) bits. No address ever reaches 2*LINE_W_P.
- Reset mid-frame: all state clears asynchronously. RAM contents are stale; rows_ok_o gates their use.

Optional Feature:
- LINE_SEQ_BORDER_REPLICATE_EN defined:
  - y=0: col_o = {pix, pix, pix}.
  - y=1: col_o = {row y-1, row y-1, pix}.
  - rows_ok_o is still driven.
- Undefined: raw RAM data is output regardless of y.

Decomposition:
- Package line_seq_pkg holds:
  - localparam ADDR_W = $clog2(2*LINE_W_P) helper function.
  - typedef col_t as a packed struct of three pixels.
- Sub-module wrap_counter (parameterised MAX, en/clr, wrap pulse) instantiated for x and y.

Test Plan:
- LINE_W_P=4, FRAME_H_P=4, continuous stream of pix = 10*y + x, col_ready_i=1 -> pixel (2,2) yields col_o = {2,12,22}, rows_ok_o=1, one cycle after accept.
- Same stream, rows 0-1 -> rows_ok_o=0. With LINE_SEQ_BORDER_REPLICATE_EN: (1,0) gives {1,1,1}; (1,1) gives {1,1,11}.
- Hold col_ready_i=0 for 5 cycles while col_valid_o=1 -> pix_ready_o=0, RAM enables 0, col_o stable; release -> next column correct.
- Stream to (3,3) -> col_eol_o=1 and col_eof_o=1 on that column; next pixel addresses slot 0, x=0.
- sof_i at (2,1) -> counters realign; ram_wr_addr_o=0, rd_addr_a=4, rd_addr_b=0.
- Assert rst_i mid-line while col_valid_o=1 -> col_valid_o drops immediately; first post-reset pixel writes address 0.
